cam_lutram_multi: RTL and testbench

- Multi-entry, parametrised successor of the single-entry LUTRAM key comparator.
- Stores ENTRIES keys of KEY_WIDTH bits in one-hot-column 32xENTRIES LUTRAM banks, one bank per 5-bit key slice.
- Lookup is combinational and returns a per-entry hit vector plus an encoded index.
- Updates use a handshaked clear-then-write sequencer; flush sweeps all bank addresses. Used for TLB/tag match in the core.

---
 rtl/cam_lutram_pkg.sv | 28 ++
 rtl/cam_lutram_multi_if.sv | 25 ++
 rtl/cam_lutram_bank.sv | 34 +++
 rtl/cam_lutram_multi.sv | 211 +++++++++++++++++++++
 tb/tb_cam_lutram_multi.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cam_lutram_pkg.sv
// Shared definitions for the multi-entry LUTRAM CAM.
//   - state_e     : sequencer states
//   - SLICE_W     : key bits per LUTRAM bank address (5 -> 32-deep banks)
//   - BANK_DEPTH  : addresses per bank
//   - packs_of()  : number of 5-bit key slices, ceil(key_width / SLICE_W)
//   - idx_w_of()  : entry index width, max(1, clog2(entries))
package cam_lutram_pkg;

  localparam int SLICE_W    = 5;
  localparam int BANK_DEPTH = 32;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CLEAR,
    WRITE,
    FLUSH
  } state_e;

  function automatic int packs_of(input int key_width);
    return (key_width + SLICE_W - 1) / SLICE_W;
  endfunction

  function automatic int idx_w_of(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/cam_lutram_multi_if.sv
// Update request channel of cam_lutram_multi (valid/ready handshake).
//   upd_valid     : request present
//   upd_ready     : request taken when valid & ready
//   upd_idx       : entry to overwrite
//   upd_key       : new key
//   upd_key_valid : 0 = invalidate the entry only
// Modports: master drives the request, slave (the CAM) returns ready.
interface cam_lutram_multi_if #(
  parameter int KEY_WIDTH = 20,
  parameter int ENTRIES   = 8
);
  import cam_lutram_pkg::*;

  localparam int IDX_W = idx_w_of(ENTRIES);

  logic                 upd_valid;
  logic                 upd_ready;
  logic [IDX_W-1:0]     upd_idx;
  logic [KEY_WIDTH-1:0] upd_key;
  logic                 upd_key_valid;

  modport master (output upd_valid, upd_idx, upd_key, upd_key_valid, input upd_ready);
  modport slave  (input upd_valid, upd_idx, upd_key, upd_key_valid, output upd_ready);

endinterface

// File: rtl/cam_lutram_bank.sv
// One 32 x ENTRIES distributed-RAM bank. Address = one 5-bit key slice,
// data bit e = "entry e has this slice value".
//   clk       : write clock
//   we_i      : write enable
//   waddr_i   : write address; wrdata_o is the current word there (for RMW)
//   wdata_i   : write data
//   raddr_i   : async lookup address
//   rdata_o   : async lookup data
module cam_lutram_bank
  import cam_lutram_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [SLICE_W-1:0] waddr_i,
  input  logic [ENTRIES-1:0] wdata_i,
  output logic [ENTRIES-1:0] wrdata_o,
  input  logic [SLICE_W-1:0] raddr_i,
  output logic [ENTRIES-1:0] rdata_o
);

  logic [ENTRIES-1:0] mem_q [BANK_DEPTH];

  // NOTE: the array has no reset so it maps onto LUTRAM; the owner's INIT
  // sweep establishes its contents after every reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign wrdata_o = mem_q[waddr_i];
  assign rdata_o  = mem_q[raddr_i];

endmodule

// File: rtl/cam_lutram_multi.sv
// Multi-entry LUTRAM CAM (TLB/tag match).
// Keys are cut into 5-bit slices; each slice indexes its own 32 x ENTRIES
// bank, and an entry hits when every bank has its bit set at the lookup slice.
//   clk, rst_n       : clock, async active-low reset
//   upd (slave)      : update handshake (idx, key, key_valid)
//   flush_i          : invalidate all entries (taken in IDLE only)
//   busy_o           : sequencer not IDLE
//   cmp_key_i        : lookup key -> hit_vec_o / hit_o / hit_idx_o (lowest)
//   multi_hit_o      : >1 entries hit; only with CAM_LUTRAM_MULTIHIT_EN,
//                      otherwise tied 0
//   rd_idx_i         : shadow readback -> rd_key_o / rd_valid_o
module cam_lutram_multi
  import cam_lutram_pkg::*;
#(
  parameter int KEY_WIDTH = 20,
  parameter int ENTRIES   = 8,
  localparam int IDX_W    = idx_w_of(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cam_lutram_multi_if.slave     upd,
  input  logic                  flush_i,
  output logic                  busy_o,
  input  logic [KEY_WIDTH-1:0]  cmp_key_i,
  output logic [ENTRIES-1:0]    hit_vec_o,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      hit_idx_o,
  output logic                  multi_hit_o,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [KEY_WIDTH-1:0]  rd_key_o,
  output logic                  rd_valid_o
);

  localparam int PACKS = packs_of(KEY_WIDTH);
  localparam int PW    = PACKS * SLICE_W;

  state_e               state_q, state_d;
  logic [SLICE_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 kv_q, kv_d;
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [KEY_WIDTH-1:0] keys_q [ENTRIES];
  logic [KEY_WIDTH-1:0] keys_d [ENTRIES];

  logic                 idx_ok;
  logic [ENTRIES-1:0]   idx_oh;
  logic [PW-1:0]        old_ext, new_ext, cmp_ext;
  logic                 bank_we;
  logic [SLICE_W-1:0]   bank_waddr [PACKS];
  logic [SLICE_W-1:0]   bank_raddr [PACKS];
  logic [ENTRIES-1:0]   bank_wdata [PACKS];
  logic [ENTRIES-1:0]   bank_wrd   [PACKS];
  logic [ENTRIES-1:0]   bank_rdata [PACKS];

  assign idx_ok = (32'(idx_q) < ENTRIES);
  assign idx_oh = ENTRIES'(1) << idx_q;

  // Keys are zero-extended to whole slices.
  always_comb begin
    old_ext = '0;
    new_ext = '0;
    cmp_ext = '0;
    old_ext[KEY_WIDTH-1:0] = keys_q[idx_q];
    new_ext[KEY_WIDTH-1:0] = key_q;
    cmp_ext[KEY_WIDTH-1:0] = cmp_key_i;
  end

  // Sequencer
  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    key_d   = key_q;
    kv_d    = kv_q;
    valid_d = valid_q;
    keys_d  = keys_q;
    bank_we = 1'b0;
    unique case (state_q)
      INIT, FLUSH: begin
        bank_we = 1'b1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(BANK_DEPTH - 1)) begin
          state_d = IDLE;
          if (state_q == FLUSH) valid_d = '0;
        end
      end
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (upd.upd_valid) begin
          idx_d   = upd.upd_idx;
          key_d   = upd.upd_key;
          kv_d    = upd.upd_key_valid;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // Only a valid entry has bits in the banks to remove.
        bank_we = idx_ok && valid_q[idx_q];
        state_d = WRITE;
      end
      WRITE: begin
        bank_we = idx_ok && kv_q;
        if (idx_ok) begin
          valid_d[idx_q] = kv_q;
          keys_d[idx_q]  = key_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-bank addressing: sweep address in INIT/FLUSH, old key slice while
  // clearing, new key slice while writing; one bit changes per write.
  always_comb begin
    for (int p = 0; p < PACKS; p++) begin
      bank_raddr[p] = cmp_ext[p*SLICE_W +: SLICE_W];
      bank_waddr[p] = cnt_q;
      bank_wdata[p] = '0;
      if (state_q == CLEAR) begin
        bank_waddr[p] = old_ext[p*SLICE_W +: SLICE_W];
        bank_wdata[p] = bank_wrd[p] & ~idx_oh;
      end else if (state_q == WRITE) begin
        bank_waddr[p] = new_ext[p*SLICE_W +: SLICE_W];
        bank_wdata[p] = bank_wrd[p] | idx_oh;
      end
    end
  end

  for (genvar p = 0; p < PACKS; p++) begin : g_bank
    cam_lutram_bank #(.ENTRIES(ENTRIES)) u_bank (
      .clk      (clk),
      .we_i     (bank_we),
      .waddr_i  (bank_waddr[p]),
      .wdata_i  (bank_wdata[p]),
      .wrdata_o (bank_wrd[p]),
      .raddr_i  (bank_raddr[p]),
      .rdata_o  (bank_rdata[p])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      valid_q <= valid_d;
    end
  end

  // Shadow keys are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    keys_q <= keys_d;
  end

  // A simultaneous flush wins, so ready drops to keep valid&ready meaning
  // "accepted".
  assign upd.upd_ready = (state_q == IDLE) && !flush_i;
  assign busy_o        = (state_q != IDLE);

  // Lookup; banks hold garbage until the INIT sweep completes.
  always_comb begin
    hit_vec_o = '1;
    for (int p = 0; p < PACKS; p++) hit_vec_o &= bank_rdata[p];
    if (state_q == INIT) hit_vec_o = '0;
  end

  assign hit_o = |hit_vec_o;

  always_comb begin
    hit_idx_o = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (hit_vec_o[e]) hit_idx_o = IDX_W'(e);
    end
  end

`ifdef CAM_LUTRAM_MULTIHIT_EN
  assign multi_hit_o = ($countones(hit_vec_o) > 1);
`else
  assign multi_hit_o = 1'b0;
`endif

  always_comb begin
    rd_key_o   = '0;
    rd_valid_o = 1'b0;
    if (32'(rd_idx_i) < ENTRIES) begin
      rd_key_o   = keys_q[rd_idx_i];
      rd_valid_o = valid_q[rd_idx_i];
    end
  end

endmodule

// File: tb/tb_cam_lutram_multi.sv
// Directed bench for cam_lutram_multi (KEY_WIDTH=20, ENTRIES=8).
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_cam_lutram_multi;

  localparam int KW = 20;
  localparam int EN = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          busy_o;
  logic [KW-1:0] cmp_key_i = '0;
  logic [EN-1:0] hit_vec_o;
  logic          hit_o;
  logic [IW-1:0] hit_idx_o;
  logic          multi_hit_o;
  logic [IW-1:0] rd_idx_i = '0;
  logic [KW-1:0] rd_key_o;
  logic          rd_valid_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef CAM_LUTRAM_MULTIHIT_EN
  localparam logic MULTI_EXP = 1'b1;
`else
  localparam logic MULTI_EXP = 1'b0;
`endif

  cam_lutram_multi_if #(.KEY_WIDTH(KW), .ENTRIES(EN)) upd_if ();

  cam_lutram_multi #(.KEY_WIDTH(KW), .ENTRIES(EN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd         (upd_if),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .cmp_key_i   (cmp_key_i),
    .hit_vec_o   (hit_vec_o),
    .hit_o       (hit_o),
    .hit_idx_o   (hit_idx_o),
    .multi_hit_o (multi_hit_o),
    .rd_idx_i    (rd_idx_i),
    .rd_key_o    (rd_key_o),
    .rd_valid_o  (rd_valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [KW-1:0] key);
    cmp_key_i = key;
    #1;
  endtask

  // Presents one request, checks it is accepted at the next edge (T) and
  // returns just after edge T.
  task automatic start_update(input logic [IW-1:0] idx, input logic [KW-1:0] key,
                              input logic kv);
    upd_if.upd_valid     = 1'b1;
    upd_if.upd_idx       = idx;
    upd_if.upd_key       = key;
    upd_if.upd_key_valid = kv;
    check("upd_ready", 64'(upd_if.upd_ready), 64'd1);
    tick();
    upd_if.upd_valid = 1'b0;
  endtask

  task automatic full_update(input logic [IW-1:0] idx, input logic [KW-1:0] key,
                             input logic kv);
    start_update(idx, key, kv);
    tick();
    tick();
  endtask

  task automatic check_init_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      check(tag, {61'd0, busy_o, hit_o, upd_if.upd_ready}, {61'd0, 3'b100});
      tick();
    end
    check({tag, "_done"}, {62'd0, busy_o, upd_if.upd_ready}, {62'd0, 2'b01});
  endtask

  task automatic check_all_invalid(input string tag);
    for (int i = 0; i < EN; i++) begin
      rd_idx_i = IW'(i);
      #1;
      check(tag, 64'(rd_valid_o), 64'd0);
    end
  endtask

  initial begin
    upd_if.upd_valid     = 1'b0;
    upd_if.upd_idx       = '0;
    upd_if.upd_key       = '0;
    upd_if.upd_key_valid = 1'b0;

    // Reset and INIT sweep
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_init_sweep("init");
    lookup(20'h00000); check("init_miss0", 64'(hit_vec_o), 64'h0);
    lookup(20'h12345); check("init_miss1", 64'(hit_o), 64'd0);
    lookup(20'hFFFFF); check("init_miss2", 64'(hit_o), 64'd0);
    check_all_invalid("init_rd_valid");

    // idx 3 <- 0x12345, two-cycle visibility
    lookup(20'h12345);
    start_update(3'd3, 20'h12345, 1'b1);
    tick();
    check("t1_miss", 64'(hit_o), 64'd0);
    tick();
    check("t2_hit", 64'(hit_o), 64'd1);
    check("t2_idx", 64'(hit_idx_o), 64'd3);
    check("t2_vec", 64'(hit_vec_o), 64'h08);
    check("t2_busy", 64'(busy_o), 64'd0);

    // overwrite idx 3 with 0x0ABCD
    start_update(3'd3, 20'h0ABCD, 1'b1);
    check("ow_t0_oldhit", 64'(hit_o), 64'd1);
    tick();
    check("ow_t1_oldmiss", 64'(hit_o), 64'd0);
    lookup(20'h0ABCD);
    check("ow_t1_newmiss", 64'(hit_o), 64'd0);
    tick();
    check("ow_t2_newhit", 64'(hit_vec_o), 64'h08);
    check("ow_t2_idx", 64'(hit_idx_o), 64'd3);
    lookup(20'h12345);
    check("ow_oldmiss", 64'(hit_o), 64'd0);
    rd_idx_i = 3'd3;
    #1;
    check("rd_key3", 64'(rd_key_o), 64'h0ABCD);
    check("rd_valid3", 64'(rd_valid_o), 64'd1);
    rd_idx_i = 3'd2;
    #1;
    check("rd_valid2", 64'(rd_valid_o), 64'd0);

    // duplicate key in idx 1 and idx 5
    full_update(3'd1, 20'h00001, 1'b1);
    full_update(3'd5, 20'h00001, 1'b1);
    lookup(20'h00001);
    check("dup_vec", 64'(hit_vec_o), 64'h22);
    check("dup_idx", 64'(hit_idx_o), 64'd1);
    check("dup_multi", 64'(multi_hit_o), 64'(MULTI_EXP));
    lookup(20'h0ABCD);
    check("single_vec", 64'(hit_vec_o), 64'h08);
    check("single_multi", 64'(multi_hit_o), 64'd0);

    // identical rewrite of idx 5, then invalidate idx 1
    full_update(3'd5, 20'h00001, 1'b1);
    lookup(20'h00001);
    check("rewrite_vec", 64'(hit_vec_o), 64'h22);
    full_update(3'd1, 20'h00001, 1'b0);
    check("inval_vec", 64'(hit_vec_o), 64'h20);
    check("inval_idx", 64'(hit_idx_o), 64'd5);
    rd_idx_i = 3'd1;
    #1;
    check("inval_rd_valid", 64'(rd_valid_o), 64'd0);

    // flush and update in the same IDLE cycle: flush wins
    flush_i              = 1'b1;
    upd_if.upd_valid     = 1'b1;
    upd_if.upd_idx       = 3'd0;
    upd_if.upd_key       = 20'h55555;
    upd_if.upd_key_valid = 1'b1;
    tick();
    flush_i          = 1'b0;
    upd_if.upd_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("flush_busy", {62'd0, busy_o, upd_if.upd_ready}, {62'd0, 2'b10});
      tick();
    end
    check("flush_done", 64'(busy_o), 64'd0);
    lookup(20'h0ABCD); check("flush_miss0", 64'(hit_vec_o), 64'h0);
    lookup(20'h00001); check("flush_miss1", 64'(hit_vec_o), 64'h0);
    lookup(20'h55555); check("flush_miss2", 64'(hit_vec_o), 64'h0);
    check_all_invalid("flush_rd_valid");

    // reset in the middle of WRITE
    full_update(3'd2, 20'h0F0F0, 1'b1);
    lookup(20'h0F0F0);
    check("pre_rst_hit", 64'(hit_vec_o), 64'h04);
    start_update(3'd6, 20'h33333, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy_o), 64'd1);
    check("rst_hit", 64'(hit_o), 64'd0);
    check("rst_ready", 64'(upd_if.upd_ready), 64'd0);
    rd_idx_i = 3'd2;
    #1;
    check("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    rst_n = 1'b1;
    check_init_sweep("reinit");
    lookup(20'h0F0F0); check("post_rst_miss0", 64'(hit_vec_o), 64'h0);
    lookup(20'h33333); check("post_rst_miss1", 64'(hit_vec_o), 64'h0);
    check_all_invalid("post_rst_rd_valid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
